// File: rtl/key_mode_sel.sv
// Push-button mode selector: synchronises an active-low key, debounces press and release,
// and steps a 2-bit mode on each release. Define KEY_LONG_PRESS_EN to add the long-press reset to 0.
module key_mode_sel #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic [1:0] sw,
    output logic       sw_chg,
    output logic       key_level
);

    localparam int DB_CNT = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W  = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_CNT = CLK_FREQ / 1000 * LONG_MS;
    localparam int HOLD_W   = $clog2(LONG_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CNT - 2);
`endif

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sw_reg, sw_next;
    logic             sw_chg_reg, sw_chg_next;
    logic             level_reg, level_next;
    logic             key_sync;
    logic             inc;
`ifdef KEY_LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              long_done_reg, long_done_next;
    logic              long_fire;
`endif

    assign key_sync  = sync_reg[1];
    assign sw        = sw_reg;
    assign sw_chg    = sw_chg_reg;
    assign key_level = level_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= 2'b11;
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            sw_reg     <= 2'd0;
            sw_chg_reg <= 1'b0;
            level_reg  <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            hold_reg      <= '0;
            long_done_reg <= 1'b0;
`endif
        end else begin
            sync_reg   <= {sync_reg[0], key_in};
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            sw_reg     <= sw_next;
            sw_chg_reg <= sw_chg_next;
            level_reg  <= level_next;
`ifdef KEY_LONG_PRESS_EN
            hold_reg      <= hold_next;
            long_done_reg <= long_done_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        sw_next     = sw_reg;
        sw_chg_next = 1'b0;
        level_next  = level_reg;
        inc         = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        hold_next      = hold_reg;
        long_done_next = long_done_reg;
        long_fire      = 1'b0;
        // Hold keeps running through release bounces; it fires once as it reaches LONG_CNT-1.
        if (state_reg == PRESSED || state_reg == DEB_REL) begin
            if (hold_reg != HOLD_SAT)
                hold_next = hold_reg + HOLD_W'(1);
            if (hold_reg == HOLD_FIRE && !long_done_reg) begin
                long_fire      = 1'b1;
                long_done_next = 1'b1;
            end
        end
`endif
        unique case (state_reg)
            IDLE: begin
                if (!key_sync) begin
                    state_next = DEB_PRESS;
                    cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (key_sync) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                    level_next = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                    hold_next  = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_sync) begin
                    state_next = DEB_REL;
                    cnt_next   = '0;
                end
            end
            DEB_REL: begin
                if (!key_sync) begin
                    state_next = PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    level_next = 1'b0;
`ifdef KEY_LONG_PRESS_EN
                    inc            = !long_done_reg && !long_fire;
                    long_done_next = 1'b0;
`else
                    inc = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (inc) begin
            sw_next     = sw_reg + 2'd1;
            sw_chg_next = 1'b1;
        end
`ifdef KEY_LONG_PRESS_EN
        if (long_fire) begin
            sw_next     = 2'd0;
            sw_chg_next = 1'b1;
        end
`endif
    end

endmodule
